iic_eeprom_slave: RTL

- I2C responder modelling a 24C02-style EEPROM (256 x 8) on the same SCL/SDA bus as the team's iic master.
- Synthesizable; used as the on-chip/bench partner for master bring-up.
- Supports byte/sequential write, random read, current-address read and sequential read.
- Oversamples SCL/SDA with the 50 MHz system clock; never drives SCL (no clock stretching).

---
 rtl/iic_eeprom_slave.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/iic_eeprom_slave.sv
// iic_eeprom_slave: 24C02-style I2C EEPROM responder, SCL/SDA oversampled on clk_50M, open-drain sda, no clock stretching
module iic_eeprom_slave #(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int ADDR_W = 8
) (
  input  logic              clk_50M,
  input  logic              rst,
  input  logic              scl,
  inout  wire               sda,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy
);
  localparam int DEPTH = 1 << ADDR_W;
  typedef enum logic [3:0] {IDLE, DEV, ACK_DEV, WADDR, ACK_WA, WR_BYTE, ACK_WR, RD_BYTE, RD_ACK} state_t;
  state_t state, state_n;
  logic [7:0] mem [DEPTH];
  logic scl_s1, scl_s2, scl_h, sda_s1, sda_s2, sda_h;
  logic [7:0] sh, sh_n;
  logic [2:0] cnt, cnt_n;
  logic [ADDR_W-1:0] ptr, ptr_n, ptr_inc, wr_addr_n;
  logic oe, oe_n, ack_on, ack_n, rw, rw_n, busy_n, wr_en_n;
  logic [7:0] wr_data_n, rx, cur, nxt;
  logic rise, fall, start, stop;
  assign sda = oe ? 1'b0 : 1'bz;
  assign rise = scl_s2 & ~scl_h;
  assign fall = ~scl_s2 & scl_h;
  // own low drive on sda must never be decoded as a bus condition
  assign start = scl_s2 & scl_h & ~sda_s2 & sda_h & ~oe;
  assign stop = scl_s2 & scl_h & sda_s2 & ~sda_h & ~oe;
  assign rx = {sh[6:0], sda_s2};
  assign ptr_inc = ptr + ADDR_W'(1);
  assign cur = mem[ptr];
  assign nxt = mem[ptr_inc];
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      {scl_s1, scl_s2, scl_h, sda_s1, sda_s2, sda_h} <= '1;
    end else begin
      {scl_s1, scl_s2, scl_h} <= {scl, scl_s1, scl_s2};
      {sda_s1, sda_s2, sda_h} <= {sda, sda_s1, sda_s2};
    end
  end
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sh <= '0;
      cnt <= '0;
      ptr <= '0;
      oe <= 1'b0;
      ack_on <= 1'b0;
      rw <= 1'b0;
      busy <= 1'b0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state <= state_n;
      sh <= sh_n;
      cnt <= cnt_n;
      ptr <= ptr_n;
      oe <= oe_n;
      ack_on <= ack_n;
      rw <= rw_n;
      busy <= busy_n;
      wr_en <= wr_en_n;
      wr_addr <= wr_addr_n;
      wr_data <= wr_data_n;
    end
  end
  always_ff @(posedge clk_50M) begin
    if (wr_en_n) mem[ptr] <= rx;
  end
  always_comb begin
    state_n = state;
    sh_n = sh;
    cnt_n = cnt;
    ptr_n = ptr;
    oe_n = oe;
    ack_n = ack_on;
    rw_n = rw;
    busy_n = busy;
    wr_en_n = 1'b0;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;
    if (start || stop) begin
      state_n = start ? DEV : IDLE;
      cnt_n = '0;
      oe_n = 1'b0;
      ack_n = 1'b0;
      busy_n = 1'b0;
    end else if (rise) begin
      case (state)
        DEV, WADDR, WR_BYTE: begin
          sh_n = rx;
          cnt_n = cnt + 3'd1;
          if (cnt == 3'd7) begin
            if (state == DEV) begin
              state_n = (rx[7:1] == DEV_ADDR) ? ACK_DEV : IDLE;
              busy_n = rx[7:1] == DEV_ADDR;
              rw_n = rx[0];
            end else if (state == WADDR) begin
              ptr_n = rx[ADDR_W-1:0];
              state_n = ACK_WA;
            end else begin
              wr_en_n = 1'b1;
              wr_addr_n = ptr;
              wr_data_n = rx;
              ptr_n = ptr_inc;
              state_n = ACK_WR;
            end
          end
        end
        RD_ACK: if (!ack_on) begin
          state_n = sda_s2 ? IDLE : RD_ACK;
          busy_n = busy & ~sda_s2;
          ptr_n = sda_s2 ? ptr : ptr_inc;
          sh_n = nxt;
          ack_n = ~sda_s2;
        end
        default: ;
      endcase
    end else if (fall) begin
      case (state)
        ACK_DEV, ACK_WA, ACK_WR: begin
          ack_n = ~ack_on;
          oe_n = ~ack_on;
          cnt_n = '0;
          if (ack_on) begin
            state_n = (state != ACK_DEV) ? WR_BYTE : rw ? RD_BYTE : WADDR;
            sh_n = (state == ACK_DEV && rw) ? {cur[6:0], 1'b0} : sh;
            oe_n = state == ACK_DEV && rw && !cur[7];
          end
        end
        RD_BYTE: begin
          cnt_n = cnt + 3'd1;
          oe_n = (cnt == 3'd7) ? 1'b0 : ~sh[7];
          sh_n = {sh[6:0], 1'b0};
          state_n = (cnt == 3'd7) ? RD_ACK : RD_BYTE;
        end
        RD_ACK: if (ack_on) begin
          oe_n = ~sh[7];
          sh_n = {sh[6:0], 1'b0};
          cnt_n = '0;
          ack_n = 1'b0;
          state_n = RD_BYTE;
        end
        default: ;
      endcase
    end
  end
endmodule
